// File: rtl/normalize_unit.sv
// -----------------------------------------------------------------------------
// normalize_unit
//
// Normalizes a 32-bit operand by shifting it left until its most significant
// bit carries information. It works as a 5-step binary search: shift by 16,
// then 8, 4, 2 and 1, each only if the bits that would leave the top are
// redundant.
//   signed_mode = 0 : the redundant bits are leading zeros; the result has
//                     data_out[31] = 1.
//   signed_mode = 1 : the redundant bits are extra copies of the sign bit; the
//                     result has data_out[31] != data_out[30].
// A zero operand, or all ones in signed mode, gives the maximum shift of 31.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   in_valid     operand offered
//   in_ready     operand can be accepted (high only in IDLE)
//   data_in      operand to normalize
//   signed_mode  0: count leading zeros, 1: count redundant sign bits
//   out_valid    result available (DONE)
//   out_ready    consumer accepts the result
//   data_out     data_in shifted left by shift_count, zero-filled
//   shift_count  applied left-shift amount, 0..31
//   zero         captured operand was 0x00000000
// -----------------------------------------------------------------------------
module normalize_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic        signed_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [4:0]  shift_count,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q,  work_d;   // working register, becomes data_out
  logic [4:0]  count_q, count_d;  // accumulated shift, at most 16+8+4+2+1
  logic [2:0]  step_q,  step_d;   // k of the current search step, s = 2^k
  logic        mode_q,  mode_d;
  logic        zero_q,  zero_d;

  logic [5:0]  s_amt;   // 1..16
  logic [31:0] top_u;   // top s bits, moved down to the LSBs
  logic [31:0] top_s;   // top s+1 bits, sign-extended down to the LSBs
  logic        hit;     // the top bits are redundant, so shift by s

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    step_d  = step_q;
    mode_d  = mode_q;
    zero_d  = zero_q;

    s_amt = 6'd1 << step_q;
    top_u = work_q >> (6'd32 - s_amt);
    // An arithmetic shift by 31-s leaves s+1 copies of the top bits. The
    // result is all zeros or all ones exactly when those bits all agree.
    top_s = $signed(work_q) >>> (6'd31 - s_amt);
    hit   = mode_q ? ((top_s == '0) || (top_s == '1)) : (top_u == '0);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          mode_d  = signed_mode;
          zero_d  = (data_in == 32'd0);
          count_d = 5'd0;
          step_d  = 3'd4;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          work_d  = work_q << s_amt;
          count_d = count_q + s_amt[4:0];
        end
        if (step_q == 3'd0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the clock edge no matter what order the
  // simulator runs the always blocks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      count_q <= 5'd0;
      step_q  <= 3'd0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign data_out    = work_q;
  assign shift_count = count_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_normalize_unit.sv
// -----------------------------------------------------------------------------
// tb_normalize_unit
//
// Self-checking bench for normalize_unit. It runs directed operands with known
// results, a held-result and back-to-back accept sequence, and a reset abort in
// mid-search. It then runs randomized operands, which are compared against a
// reference model that counts redundant leading bits one at a time.
// -----------------------------------------------------------------------------
module tb_normalize_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [4:0]  shift_count;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  normalize_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .shift_count (shift_count),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs are driven, and outputs sampled, 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: count leading bits one at a time. Unsigned counts leading
  // zeros. Signed counts the bits equal to the sign and drops one of them,
  // because the sign bit itself must stay. The count is capped at 31.
  task automatic model(input logic [31:0] d, input logic m,
                       output logic [31:0] eo, output logic [4:0] sc, output logic ez);
    int n = 0;
    if (!m) begin
      while (n < 32 && d[31-n] == 1'b0) n++;
    end else begin
      while (n < 32 && d[31-n] == d[31]) n++;
      n = n - 1;
    end
    if (n > 31) n = 31;
    sc = 5'(n);
    eo = d << n;
    ez = (d == 32'd0);
  endtask

  task automatic offer(input logic [31:0] d, input logic m);
    in_valid    = 1'b1;
    data_in     = d;
    signed_mode = m;
  endtask

  // The operand is already offered, and the next edge accepts it. While the
  // unit works, the inputs are scrambled. Then the latency and the result are
  // checked.
  task automatic run_check(input string tag, input logic [31:0] ed,
                           input logic [4:0] es, input logic ez);
    int lat = 0;
    step();                         // accept edge
    check({tag, ".accepted"}, 32'(in_ready), 32'd0);
    do begin
      in_valid    = 1'($urandom);
      data_in     = $urandom;
      signed_mode = 1'($urandom);
      step();
      lat++;
    end while (!out_valid && lat < 10);
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd5);
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, ".data_out"}, data_out, ed);
    check({tag, ".shift_count"}, 32'(shift_count), 32'(es));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".rel_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic [31:0] ed;
    logic [4:0]  es;
    logic        ez;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] eo;
    logic [4:0]  sc;
    logic        ez;
    logic [31:0] held_d;
    logic [4:0]  held_s;

    vecs[0] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
    vecs[1] = '{32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0};
    vecs[2] = '{32'h0000_1234, 1'b1, 32'h48D0_0000, 5'd18, 1'b0};
    vecs[3] = '{32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0};
    vecs[4] = '{32'hFFFF_8000, 1'b0, 32'hFFFF_8000, 5'd0,  1'b0};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1};
    vecs[6] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1};

    rst = 1'b1; in_valid = 1'b0; data_in = 32'hDEAD_BEEF;
    signed_mode = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.data_out", data_out, 32'd0);
    check("reset.shift_count", 32'(shift_count), 32'd0);
    check("reset.zero", 32'(zero), 32'd0);

    // The first accept happens on the first edge after rst falls.
    rst = 1'b0;
    offer(vecs[0].d, vecs[0].m);
    run_check("dir0", vecs[0].ed, vecs[0].es, vecs[0].ez);
    release_result("dir0");

    for (int i = 1; i < 7; i++) begin
      offer(vecs[i].d, vecs[i].m);
      run_check($sformatf("dir%0d", i), vecs[i].ed, vecs[i].es, vecs[i].ez);
      release_result($sformatf("dir%0d", i));
    end

    // Signed all ones: the sign bit is moved to the top and everything below
    // it is zero-filled.
    offer(32'hFFFF_FFFF, 1'b1);
    run_check("ones_signed", 32'h8000_0000, 5'd31, 1'b0);

    // The result is held in DONE while new operands are offered.
    held_d = data_out;
    held_s = shift_count;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in  = (i % 2 == 0) ? 32'h0000_00FF : 32'hA5A5_0000;
      step();
      check($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("hold%0d.data_out", i), data_out, held_d);
      check($sformatf("hold%0d.shift_count", i), 32'(shift_count), 32'(held_s));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold.rel_out_valid", 32'(out_valid), 32'd0);
    check("hold.rel_in_ready", 32'(in_ready), 32'd1);
    offer(32'h0000_00FF, 1'b0);
    run_check("after_hold", 32'hFF00_0000, 5'd24, 1'b0);
    release_result("after_hold");

    // Reset during the third search cycle aborts the operand.
    offer(32'h0000_0001, 1'b0);
    step();                 // accept edge
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.data_out", data_out, 32'd0);
    check("abort.shift_count", 32'(shift_count), 32'd0);
    check("abort.zero", 32'(zero), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("abort.no_result", 32'(seen), 32'd0);
    end

    // Randomized operands compared against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic        m;
      m = 1'($urandom);
      d = $urandom >> $urandom_range(0, 31);
      if (m && $urandom_range(0, 1) == 1) d = ~d;
      model(d, m, eo, sc, ez);
      offer(d, m);
      run_check($sformatf("rnd%0d", i), eo, sc, ez);
      if ($urandom_range(0, 1) == 1) begin
        step();
      end
      release_result($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/normalize_unit.md
NORMALIZE_UNIT -- requirements
Module: normalize_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand offered.
REQ-005 in_ready  output  1  block can accept an operand (high only in IDLE).
REQ-006 data_in  input  32  operand to normalize.
REQ-007 signed_mode  input  1  0: count leading zeros; 1: count redundant sign bits (two's complement).
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 data_out  output  32  normalized operand, data_in shifted left by shift_count, zero-filled from the LSB.
REQ-011 shift_count  output  5  applied left-shift amount, 0..31.
REQ-012 zero  output  1  captured operand equalled 0x00000000.

Function
REQ-013 FSM states SHALL be IDLE, SEARCH and DONE; no other states.
REQ-014 An operand SHALL be accepted on the edge where in_valid=1 and in_ready=1; data_in and signed_mode are captured, count cleared, step set to 4, state goes to SEARCH.
REQ-015 Inputs that change after acceptance SHALL NOT affect the result.
REQ-016 SEARCH SHALL run exactly 5 cycles with step k = 4,3,2,1,0, using s = 2^k.
REQ-017 In unsigned mode, each SEARCH cycle SHALL, if the top s bits of the working register are all 0, shift the register left by s and add s to the count.
REQ-018 In signed mode, each SEARCH cycle SHALL, if the top s+1 bits are all equal, shift the register left by s and add s to the count.
REQ-019 On the step-0 edge, state SHALL go to DONE and out_valid SHALL rise, giving a latency of 5 cycles after the accept edge.
REQ-020 In DONE, data_out, shift_count and zero SHALL be held stable while out_ready=0.
REQ-021 In DONE, an edge with out_ready=1 SHALL return the FSM to IDLE, with out_valid=0 and in_ready=1 on the next cycle.
REQ-022 in_valid SHALL be ignored outside IDLE, and operations SHALL NOT overlap.
REQ-023 For a zero operand (either mode), the result SHALL be data_out=0, shift_count=31, zero=1.
REQ-024 For signed 0xFFFFFFFF, the result SHALL be data_out=0x80000000, shift_count=31, zero=0.
REQ-025 For a non-zero operand, the result SHALL satisfy the mode's normalization target: unsigned data_out[31]=1; signed data_out[31]!=data_out[30].
REQ-026 An operand that is already normalized SHALL give shift_count=0 and data_out=data_in.
REQ-027 The count SHALL be accumulated at 5-bit width; it cannot exceed 31 and SHALL NOT wrap.

Reset
REQ-028 While rst=1 at an edge, state SHALL become IDLE with data_out=0, shift_count=0, zero=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-029 Reset SHALL take priority over every other event, including acceptance and out_ready.
REQ-030 Reset in SEARCH or DONE SHALL discard the in-flight operand, with no result emitted.
REQ-031 The first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-032 Unsigned 0x00000001 -> out_valid exactly 5 cycles after the accept edge; data_out=0x80000000, shift_count=31, zero=0.
REQ-033 Unsigned 0x00F00000 -> data_out=0xF0000000, shift_count=8; signed 0x00001234 -> data_out=0x48D00000, shift_count=18.
REQ-034 Signed 0xFFFF8000 -> data_out=0x80000000, shift_count=16; unsigned 0xFFFF8000 -> unchanged, shift_count=0.
REQ-035 Input 0 in both modes -> data_out=0, shift_count=31, zero=1; signed 0xFFFFFFFF -> data_out=0x80000000, shift_count=31, zero=0.
REQ-036 out_ready held low 4 cycles in DONE with in_valid=1 and data_in toggling -> outputs stable and in_ready=0 throughout; the FSM returns to IDLE one cycle after out_ready rises, then the next operand is accepted.
REQ-037 rst pulsed during the third SEARCH cycle -> next cycle out_valid=0, in_ready=1, outputs 0, and no result appears for the aborted operand.
